// File: rtl/viewport_pkg.sv
// Shared widths, reset constants and layer record for the viewport block.
package viewport_pkg;

  localparam int ADDR_W  = 23;
  localparam int XOFF_W  = 10;
  localparam int YOFF_W  = 9;
  localparam int SCALE_W = 8;
  localparam int WIDTH_W = 10;

  localparam logic [SCALE_W-1:0] SCALE_RST = 8'h80;

  typedef struct packed {
    logic [SCALE_W-1:0] scale;
    logic [WIDTH_W-1:0] width;
    logic [XOFF_W-1:0]  x;
    logic [YOFF_W-1:0]  y;
    logic [ADDR_W-1:0]  base;
  } layer_t;

  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Three-flop synchroniser, preloaded high, with a falling-edge pulse.
module sync_edge_detect
  import viewport_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_fe
);

  logic [2:0] r_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_s <= 3'b111;
    else       r_s <= {r_s[1:0], i_d};
  end

  assign o_fe = r_s[2] & ~r_s[1];

endmodule

// File: rtl/viewport_sync_ctrl.sv
// Frame-synchronous viewport shadow registers with per-layer
// frame and line SDRAM address generation.
module viewport_sync_ctrl
  import viewport_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int H_SIZE     = 800,
  parameter int V_SIZE     = 480,
  parameter int PITCH      = 160,
  parameter int XFINE_W    = 7
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iVS,
  input  logic                          iHS,
  input  logic                          iFREE_RUN,
  input  logic                          iUPDATE,
  input  logic [NUM_LAYERS*SCALE_W-1:0] iSCALE,
  input  logic [NUM_LAYERS*WIDTH_W-1:0] iWIDTH,
  input  logic [NUM_LAYERS*XOFF_W-1:0]  iX_OFF,
  input  logic [NUM_LAYERS*YOFF_W-1:0]  iY_OFF,
  input  logic [NUM_LAYERS*ADDR_W-1:0]  iBASE,
  output logic [NUM_LAYERS*SCALE_W-1:0] oSCALE,
  output logic [NUM_LAYERS*WIDTH_W-1:0] oWIDTH,
  output logic [NUM_LAYERS*XFINE_W-1:0] oX_FINE,
  output logic [NUM_LAYERS*ADDR_W-1:0]  oFRAME_ADDR,
  output logic [NUM_LAYERS*ADDR_W-1:0]  oLINE_ADDR,
  output logic [YOFF_W-1:0]             oLINE_IDX,
  output logic                          oFRAME_LOAD,
  output logic                          oLINE_LOAD,
  output logic                          oUPDATE_ACK,
  output logic                          oPENDING
);

  localparam logic [ADDR_W-1:0] LP_H     = ADDR_W'(H_SIZE);
  localparam logic [ADDR_W-1:0] LP_PITCH = ADDR_W'(PITCH);
  localparam logic [YOFF_W-1:0] LP_VLAST = YOFF_W'(V_SIZE - 1);

  logic w_vs_fe;
  logic w_hs_fe;
  logic w_commit;

  layer_t            r_sh    [NUM_LAYERS];
  logic [ADDR_W-1:0] r_frame [NUM_LAYERS];
  logic [ADDR_W-1:0] r_line  [NUM_LAYERS];
  logic [ADDR_W-1:0] w_frame [NUM_LAYERS];

  logic              r_pending;
  logic              r_ack;
  logic              r_vs_d1;
  logic              r_frame_load;
  logic              r_line_load;
  logic [YOFF_W-1:0] r_line_idx;

  sync_edge_detect u_vs_sync (
    .i_clk (iCLK),
    .i_rst (iRST),
    .i_d   (iVS),
    .o_fe  (w_vs_fe)
  );

  sync_edge_detect u_hs_sync (
    .i_clk (iCLK),
    .i_rst (iRST),
    .i_d   (iHS),
    .o_fe  (w_hs_fe)
  );

  assign w_commit = w_vs_fe & (iFREE_RUN | r_pending);

  // A strobe landing on the commit cycle keeps pending so it is not lost.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= w_commit & r_pending & ~iUPDATE;
      if (iUPDATE)       r_pending <= 1'b1;
      else if (w_commit) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        r_sh[k].scale <= SCALE_RST;
        r_sh[k].width <= WIDTH_W'(H_SIZE);
        r_sh[k].x     <= '0;
        r_sh[k].y     <= '0;
        r_sh[k].base  <= '0;
      end
    end else if (w_commit) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        r_sh[k].scale <= iSCALE[slice_lo(k, SCALE_W) +: SCALE_W];
        r_sh[k].width <= iWIDTH[slice_lo(k, WIDTH_W) +: WIDTH_W];
        r_sh[k].x     <= iX_OFF[slice_lo(k, XOFF_W) +: XOFF_W];
        r_sh[k].y     <= iY_OFF[slice_lo(k, YOFF_W) +: YOFF_W];
        r_sh[k].base  <= iBASE[slice_lo(k, ADDR_W) +: ADDR_W];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      w_frame[k] = r_sh[k].base
                 + LP_H * ADDR_W'(r_sh[k].y)
                 + LP_PITCH * ADDR_W'(r_sh[k].x[XOFF_W-1:XFINE_W]);
    end
  end

  // Frame reload outranks a coincident line step.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_vs_d1      <= 1'b0;
      r_frame_load <= 1'b0;
      r_line_load  <= 1'b0;
      r_line_idx   <= '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
        r_frame[k] <= '0;
        r_line[k]  <= '0;
      end
    end else begin
      r_vs_d1      <= w_vs_fe;
      r_frame_load <= r_vs_d1;
      r_line_load  <= w_hs_fe;
      if (r_vs_d1) begin
        r_line_idx <= '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
          r_frame[k] <= w_frame[k];
          r_line[k]  <= w_frame[k];
        end
      end else if (w_hs_fe && (r_line_idx < LP_VLAST)) begin
        r_line_idx <= r_line_idx + 1'b1;
        for (int k = 0; k < NUM_LAYERS; k++) begin
          r_line[k] <= r_line[k] + LP_H;
        end
      end
    end
  end

  always_comb begin
    oSCALE      = '0;
    oWIDTH      = '0;
    oX_FINE     = '0;
    oFRAME_ADDR = '0;
    oLINE_ADDR  = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      oSCALE[slice_lo(k, SCALE_W) +: SCALE_W]      = r_sh[k].scale;
      oWIDTH[slice_lo(k, WIDTH_W) +: WIDTH_W]      = r_sh[k].width;
      oX_FINE[slice_lo(k, XFINE_W) +: XFINE_W]     = r_sh[k].x[XFINE_W-1:0];
      oFRAME_ADDR[slice_lo(k, ADDR_W) +: ADDR_W]   = r_frame[k];
      oLINE_ADDR[slice_lo(k, ADDR_W) +: ADDR_W]    = r_line[k];
    end
  end

  assign oLINE_IDX   = r_line_idx;
  assign oFRAME_LOAD = r_frame_load;
  assign oLINE_LOAD  = r_line_load;
  assign oUPDATE_ACK = r_ack;
  assign oPENDING    = r_pending;

endmodule

// File: tb/tb_viewport_sync_ctrl.sv
// Directed bench for viewport_sync_ctrl: commit handshake,
// frame/line address generation, saturation, wrap and reset.
module tb_viewport_sync_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iVS  = 1'b1;
  logic        iHS  = 1'b1;
  logic        iFREE_RUN = 1'b0;
  logic        iUPDATE   = 1'b0;
  logic [15:0] iSCALE = '0;
  logic [19:0] iWIDTH = '0;
  logic [19:0] iX_OFF = '0;
  logic [17:0] iY_OFF = '0;
  logic [45:0] iBASE  = '0;
  logic [15:0] oSCALE;
  logic [19:0] oWIDTH;
  logic [13:0] oX_FINE;
  logic [45:0] oFRAME_ADDR;
  logic [45:0] oLINE_ADDR;
  logic [8:0]  oLINE_IDX;
  logic        oFRAME_LOAD;
  logic        oLINE_LOAD;
  logic        oUPDATE_ACK;
  logic        oPENDING;

  int n_checks = 0;
  int n_errors = 0;

  logic ack3, ld3, ld4, ack4;
  logic hs_load;

  viewport_sync_ctrl dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iVS         (iVS),
    .iHS         (iHS),
    .iFREE_RUN   (iFREE_RUN),
    .iUPDATE     (iUPDATE),
    .iSCALE      (iSCALE),
    .iWIDTH      (iWIDTH),
    .iX_OFF      (iX_OFF),
    .iY_OFF      (iY_OFF),
    .iBASE       (iBASE),
    .oSCALE      (oSCALE),
    .oWIDTH      (oWIDTH),
    .oX_FINE     (oX_FINE),
    .oFRAME_ADDR (oFRAME_ADDR),
    .oLINE_ADDR  (oLINE_ADDR),
    .oLINE_IDX   (oLINE_IDX),
    .oFRAME_LOAD (oFRAME_LOAD),
    .oLINE_LOAD  (oLINE_LOAD),
    .oUPDATE_ACK (oUPDATE_ACK),
    .oPENDING    (oPENDING)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // vs_fe is high between edges 2 and 3 after iVS falls; shadow/ack
  // register at edge 3, frame load at edge 4.
  task automatic vs_frame(input logic upd, output logic a3,
                          output logic l3, output logic l4,
                          output logic a4);
    iVS = 1'b0;
    tick();
    tick();
    if (upd) iUPDATE = 1'b1;
    tick();
    iUPDATE = 1'b0;
    a3 = oUPDATE_ACK;
    l3 = oFRAME_LOAD;
    tick();
    l4 = oFRAME_LOAD;
    a4 = oUPDATE_ACK;
    tick();
    iVS = 1'b1;
    repeat (4) tick();
  endtask

  task automatic hs_pulse(output logic seen);
    seen = 1'b0;
    iHS = 1'b0;
    repeat (3) begin
      tick();
      if (oLINE_LOAD) seen = 1'b1;
    end
    iHS = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    iSCALE = 16'h4040;
    repeat (3) tick();
    chk("rst_frame_load", 64'(oFRAME_LOAD), 64'd0);
    chk("rst_pending", 64'(oPENDING), 64'd0);
    chk("rst_frame_addr", 64'(oFRAME_ADDR), 64'd0);
    chk("rst_scale", 64'(oSCALE), 64'h8080);
    chk("rst_width", 64'(oWIDTH), {44'd0, 10'd800, 10'd800});
    iRST = 1'b0;
    repeat (4) tick();

    vs_frame(1'b0, ack3, ld3, ld4, ack4);
    chk("t1_load_early", 64'(ld3), 64'd0);
    chk("t1_load", 64'(ld4), 64'd1);
    chk("t1_ack", 64'(ack3), 64'd0);
    chk("t1_frame_addr", 64'(oFRAME_ADDR), 64'd0);
    chk("t1_scale", 64'(oSCALE), 64'h8080);

    iSCALE = {8'h90, 8'h40};
    iWIDTH = {10'd400, 10'd640};
    iX_OFF = {10'd0, 10'h180};
    iY_OFF = {9'd1, 9'd10};
    iBASE  = {23'd8388508, 23'd0};
    iUPDATE = 1'b1;
    tick();
    iUPDATE = 1'b0;
    chk("t2_pending", 64'(oPENDING), 64'd1);
    vs_frame(1'b0, ack3, ld3, ld4, ack4);
    chk("t2_ack", 64'(ack3), 64'd1);
    chk("t2_ack_once", 64'(ack4), 64'd0);
    chk("t2_load", 64'(ld4), 64'd1);
    chk("t2_pending_clr", 64'(oPENDING), 64'd0);
    chk("t2_frame_addr", 64'(oFRAME_ADDR), {23'd700, 23'd8480});
    chk("t2_xfine0", 64'(oX_FINE[6:0]), 64'd0);
    chk("t2_scale", 64'(oSCALE), 64'h9040);
    chk("t2_width", 64'(oWIDTH), {44'd0, 10'd400, 10'd640});
    chk("t2_line_addr", 64'(oLINE_ADDR), {23'd700, 23'd8480});
    chk("t2_line_idx", 64'(oLINE_IDX), 64'd0);

    hs_pulse(hs_load);
    chk("t5_line_load", 64'(hs_load), 64'd1);
    hs_pulse(hs_load);
    hs_pulse(hs_load);
    chk("t5_line_addr3", 64'(oLINE_ADDR), {23'd3100, 23'd10880});
    chk("t5_line_idx3", 64'(oLINE_IDX), 64'd3);
    repeat (597) hs_pulse(hs_load);
    chk("t5_idx_sat", 64'(oLINE_IDX), 64'd479);
    chk("t5_addr_sat", 64'(oLINE_ADDR), {23'd383900, 23'd391680});

    iY_OFF = {9'd1, 9'd20};
    iSCALE = 16'h1111;
    vs_frame(1'b0, ack3, ld3, ld4, ack4);
    chk("t3_load", 64'(ld4), 64'd1);
    chk("t3_ack", 64'(ack3), 64'd0);
    chk("t3_frame_addr", 64'(oFRAME_ADDR), {23'd700, 23'd8480});
    chk("t3_scale", 64'(oSCALE), 64'h9040);
    chk("t3_line_idx", 64'(oLINE_IDX), 64'd0);

    iUPDATE = 1'b1;
    tick();
    iUPDATE = 1'b0;
    vs_frame(1'b1, ack3, ld3, ld4, ack4);
    chk("t4_no_ack", 64'(ack3 | ack4), 64'd0);
    chk("t4_pending_kept", 64'(oPENDING), 64'd1);
    chk("t4_load", 64'(ld4), 64'd1);
    chk("t4_frame_addr", 64'(oFRAME_ADDR), {23'd700, 23'd16480});
    chk("t4_scale", 64'(oSCALE), 64'h1111);
    vs_frame(1'b0, ack3, ld3, ld4, ack4);
    chk("t4_ack_next", 64'(ack3), 64'd1);
    chk("t4_pending_clr", 64'(oPENDING), 64'd0);

    iFREE_RUN = 1'b1;
    iX_OFF = {10'd0, 10'h3FF};
    iY_OFF = {9'd1, 9'd0};
    vs_frame(1'b0, ack3, ld3, ld4, ack4);
    iFREE_RUN = 1'b0;
    chk("fr_no_ack", 64'(ack3), 64'd0);
    chk("fr_frame_addr", 64'(oFRAME_ADDR), {23'd700, 23'd1120});
    chk("fr_xfine0", 64'(oX_FINE[6:0]), 64'h7F);

    iUPDATE = 1'b1;
    tick();
    iUPDATE = 1'b0;
    iVS = 1'b0;
    repeat (3) tick();
    iRST = 1'b1;
    #1;
    chk("t6_rst_frame", 64'(oFRAME_ADDR), 64'd0);
    chk("t6_rst_line", 64'(oLINE_ADDR), 64'd0);
    chk("t6_rst_idx", 64'(oLINE_IDX), 64'd0);
    chk("t6_rst_pend", 64'(oPENDING), 64'd0);
    chk("t6_rst_pulses",
        64'({oFRAME_LOAD, oLINE_LOAD, oUPDATE_ACK}), 64'd0);
    tick();
    chk("t6_rst_abort", 64'(oFRAME_LOAD), 64'd0);
    iRST = 1'b0;
    iVS = 1'b1;
    repeat (4) tick();
    chk("t6_rst_scale", 64'(oSCALE), 64'h8080);
    vs_frame(1'b0, ack3, ld3, ld4, ack4);
    chk("t6_first_load_early", 64'(ld3), 64'd0);
    chk("t6_first_load", 64'(ld4), 64'd1);
    chk("t6_frame_zero", 64'(oFRAME_ADDR), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
